// File: rtl/iamp_trim_pkg.sv
// Shared types and sizing helpers for the OTA bias-current SAR trim controller.
package iamp_trim_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRIAL  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DECIDE = 3'd4,
    FINISH = 3'd5
  } trim_state_e;

  function automatic bit nvote_ok(input int n);
    return (n >= 1) && ((n % 2) == 1);
  endfunction

  // Bits needed to hold any value in 0..max_val (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trim_majority_vote.sv
// Counts comparator ones over one vote window; maj reports a strict majority.
module trim_majority_vote
  import iamp_trim_pkg::*;
#(
  parameter int NVOTE = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  input  logic cmp,
  output logic maj
);

  localparam int VW = cnt_width(NVOTE);

  logic [VW-1:0] r_ones;

  // cmp is gated by en first so an unknown comparator outside the window is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ones <= '0;
    end else if (clr) begin
      r_ones <= '0;
    end else if (en && cmp) begin
      r_ones <= r_ones + VW'(1);
    end
  end

  assign maj = (r_ones > VW'(NVOTE / 2));

endmodule

// File: rtl/iamp_bias_trim_ctrl.sv
// SAR foreground calibration of the OTA bias DAC code using a voted comparator.
//  state  | meaning
//  IDLE   | waiting for start; code_out holds last committed code
//  TRIAL  | raise trial bit k, clear the vote counter
//  SETTLE | wait SETTLE_CYC cycles for the amplifier to settle
//  SAMPLE | take NVOTE comparator samples
//  DECIDE | keep or drop bit k, step to next bit or finish
//  FINISH | done pulse visible, code_valid set, busy low
module iamp_bias_trim_ctrl
  import iamp_trim_pkg::*;
#(
  parameter int NBIT       = 6,
  parameter int SETTLE_CYC = 16,
  parameter int NVOTE      = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            cmp,
  output logic [NBIT-1:0] code_out,
  output logic            dac_en,
  output logic            busy,
  output logic            done,
  output logic            code_valid
);

  localparam int TMR_MAX = ((SETTLE_CYC > NVOTE) ? SETTLE_CYC : NVOTE) - 1;
  localparam int TMR_W   = cnt_width(TMR_MAX);
  localparam int K_W     = cnt_width(NBIT - 1);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] VOTE_LD   = TMR_W'(NVOTE - 1);
  localparam logic [K_W-1:0]   K_TOP     = K_W'(NBIT - 1);

  if (!nvote_ok(NVOTE) || (SETTLE_CYC < 1)) begin : g_param_chk
    $error("iamp_bias_trim_ctrl: NVOTE must be odd and >= 1, SETTLE_CYC >= 1");
  end

  trim_state_e     r_state;
  trim_state_e     w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [K_W-1:0]   r_k;
  logic            w_maj;
  logic            w_vote_clr;
  logic            w_vote_en;

  assign w_vote_clr = (r_state == TRIAL);
  assign w_vote_en  = (r_state == SAMPLE);

  trim_majority_vote #(
    .NVOTE (NVOTE)
  ) u_vote (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_vote_clr),
    .en   (w_vote_en),
    .cmp  (cmp),
    .maj  (w_maj)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = TRIAL;
      TRIAL:   w_state_nxt = SETTLE;
      SETTLE:  if (r_tmr == '0) w_state_nxt = SAMPLE;
      SAMPLE:  if (r_tmr == '0) w_state_nxt = DECIDE;
      DECIDE:  w_state_nxt = (r_k == '0) ? FINISH : TRIAL;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs update on the edge entering FINISH so done/code_valid are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      code_out   <= '0;
      dac_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      code_valid <= 1'b0;
      r_k        <= K_TOP;
      r_tmr      <= '0;
    end else begin
      done <= (r_state == DECIDE) && (r_k == '0);
      case (r_state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            dac_en     <= 1'b1;
            code_valid <= 1'b0;
            code_out   <= {1'b1, {(NBIT-1){1'b0}}};
            r_k        <= K_TOP;
          end
        end
        TRIAL: begin
          code_out[r_k] <= 1'b1;
          r_tmr         <= SETTLE_LD;
        end
        SETTLE: begin
          r_tmr <= (r_tmr == '0) ? VOTE_LD : r_tmr - TMR_W'(1);
        end
        SAMPLE: begin
          if (r_tmr != '0) r_tmr <= r_tmr - TMR_W'(1);
        end
        DECIDE: begin
          code_out[r_k] <= w_maj;
          if (r_k == '0) begin
            busy       <= 1'b0;
            code_valid <= 1'b1;
          end else begin
            r_k <= r_k - K_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iamp_bias_trim_ctrl.sv
// Randomized bench for the bias trim SAR: reference is the ideal binary search on a target.
module tb_iamp_bias_trim_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start_a = 1'b0, cmp_a = 1'b0;
  logic       start_b = 1'b0, cmp_b = 1'b0;
  logic [5:0] code_a;
  logic [3:0] code_b;
  logic       dac_en_a, busy_a, done_a, valid_a;
  logic       dac_en_b, busy_b, done_b, valid_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cur_sel = 0;
  int w_code, w_dac_en, w_busy, w_done, w_valid;

  always #5 clk = ~clk;

  iamp_bias_trim_ctrl #(.NBIT(6), .SETTLE_CYC(4), .NVOTE(3)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .cmp(cmp_a), .code_out(code_a),
    .dac_en(dac_en_a), .busy(busy_a), .done(done_a), .code_valid(valid_a)
  );

  iamp_bias_trim_ctrl #(.NBIT(4), .SETTLE_CYC(1), .NVOTE(1)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .cmp(cmp_b), .code_out(code_b),
    .dac_en(dac_en_b), .busy(busy_b), .done(done_b), .code_valid(valid_b)
  );

  always_comb begin
    w_code   = (cur_sel != 0) ? int'(code_b)   : int'(code_a);
    w_dac_en = (cur_sel != 0) ? int'(dac_en_b) : int'(dac_en_a);
    w_busy   = (cur_sel != 0) ? int'(busy_b)   : int'(busy_a);
    w_done   = (cur_sel != 0) ? int'(done_b)   : int'(done_a);
    w_valid  = (cur_sel != 0) ? int'(valid_b)  : int'(valid_a);
  end

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start_b = v; else start_a = v;
  endtask

  task automatic set_cmp(input int sel, input logic v);
    if (sel != 0) cmp_b = v; else cmp_a = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code"},  w_code,   0);
    chk({tag, "_dacen"}, w_dac_en, 0);
    chk({tag, "_busy"},  w_busy,   0);
    chk({tag, "_done"},  w_done,   0);
    chk({tag, "_valid"}, w_valid,  0);
  endtask

  // One calibration. Comparator truth is (trial code <= target); the schedule of
  // sample windows follows the documented per-bit cycle budget. Outside the
  // windows cmp is random to prove it is ignored there.
  task automatic run_cal(input int sel, input int target, input bit noise, input bit hs);
    int nb, s, v, b, lat, last, exp_code, maxc;
    int dec, trial, flip, o, k, j, first_done, dones, dones2, rnd;
    bit truth;
    logic cval;
    nb = (sel != 0) ? 4 : 6;
    s  = (sel != 0) ? 1 : 4;
    v  = (sel != 0) ? 1 : 3;
    b  = 2 + s + v;
    lat  = 1 + nb * b;
    last = hs ? (2 * lat + 3) : (lat + 3);
    maxc = (1 << nb) - 1;
    exp_code = (target < 0) ? 0 : ((target > maxc) ? maxc : target);
    dec = 0; trial = 0; flip = 0; first_done = -1; dones = 0; dones2 = 0;
    cur_sel = sel;
    @(negedge clk);
    set_start(sel, 1'b1);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      set_start(sel, hs && (c == 10 || c == 54 || c == 55 || c == lat + 1));
      o = (c - 1) % b;
      k = nb - 1 - (c - 1) / b;
      if (c <= nb * b && o >= s + 1 && o <= s + v) begin
        j = o - s - 1;
        if (j == 0) begin
          trial = dec | (1 << k);
          flip  = $urandom_range(v - 1, 0);
          chk("trial_code", w_code, trial);
        end
        truth = (trial <= target);
        cval  = (noise && j == flip) ? !truth : truth;
        if (j == v - 1 && truth) dec = trial;
      end else begin
        rnd  = $urandom;
        cval = rnd[0];
      end
      set_cmp(sel, cval);
      if (c == 1) begin
        chk("accept_busy",  w_busy,   1);
        chk("accept_valid", w_valid,  0);
        chk("accept_dacen", w_dac_en, 1);
      end
      if (w_done != 0) begin
        if (c <= lat + 1) dones++; else dones2++;
        if (first_done < 0) first_done = c;
      end
      if (c == lat + 1) begin
        chk("final_code",  w_code,   exp_code);
        chk("final_valid", w_valid,  1);
        chk("final_busy",  w_busy,   0);
        chk("final_dacen", w_dac_en, 1);
      end
      if (hs && c == lat + 2) begin
        chk("restart_valid", w_valid, 0);
        chk("restart_busy",  w_busy,  1);
      end
      if (!hs && c == lat + 3) chk("hold_code", w_code, exp_code);
    end
    chk("latency",    first_done, lat);
    chk("done_count", dones, 1);
    if (hs) chk("restart_done_count", dones2, 1);
    set_cmp(sel, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    cur_sel = 0;
    chk_all_zero("por_a");
    cur_sel = 1;
    chk_all_zero("por_b");
    rstn = 1'b1;
    @(negedge clk);

    run_cal(0, 37, 1'b0, 1'b0);
    run_cal(0, 63, 1'b0, 1'b0);
    run_cal(0, -1, 1'b0, 1'b0);
    run_cal(0, 20, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) run_cal(0, int'($urandom_range(63, 0)), 1'b1, 1'b0);
    run_cal(0, int'($urandom_range(63, 0)), 1'b0, 1'b1);

    // Abort mid-SETTLE of the first bit; reset must clear outputs without a clock.
    cur_sel = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_cal(0, 37, 1'b0, 1'b0);

    run_cal(1, 0, 1'b0, 1'b0);
    run_cal(1, 15, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cal(1, int'($urandom_range(15, 0)), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
